// File: rtl/ex_alu_csr_unit_if.sv
// Execute-stage bus for ex_alu_csr_unit: ALU operands/decode inputs, CSR access
// signals and every datapath/CSR output. clk and rst stay plain ports on the block.
interface ex_alu_csr_unit_if #(
  parameter int XLEN = 32
);
  logic [2:0]      alu_op;
  logic [2:0]      func3;
  logic            func7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            csr_sel;
  logic            csr_w_en;
  logic [11:0]     csr_w_addr;
  logic [XLEN-1:0] csr_w_data;
  logic [11:0]     csr_r_addr;
  logic [1:0]      priv_mode;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_o;
  logic            br_mark;
  logic [XLEN-1:0] csr_r_data;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] o_mstatus;
  logic [XLEN-1:0] o_mtvec;
  logic [XLEN-1:0] o_mepc;
  logic [XLEN-1:0] o_mcause;
  logic [XLEN-1:0] o_mtval;
  logic [XLEN-1:0] o_satp;
  logic [XLEN-1:0] o_sepc;

  modport master (
    output alu_op, func3, func7, op_a, op_b, csr_sel, csr_w_en, csr_w_addr,
           csr_w_data, csr_r_addr, priv_mode,
    input  alu_ctrl, alu_o, br_mark, csr_r_data, result,
           o_mstatus, o_mtvec, o_mepc, o_mcause, o_mtval, o_satp, o_sepc
  );

  modport slave (
    input  alu_op, func3, func7, op_a, op_b, csr_sel, csr_w_en, csr_w_addr,
           csr_w_data, csr_r_addr, priv_mode,
    output alu_ctrl, alu_o, br_mark, csr_r_data, result,
           o_mstatus, o_mtvec, o_mepc, o_mcause, o_mtval, o_satp, o_sepc
  );
endinterface

// File: rtl/ex_alu_csr_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU with branch flag, M/S CSR file.
// Define CSR_PRIV_CHECK_EN to enforce privilege on CSR writes (off by default).
module ex_alu_csr_unit #(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                rst,
  ex_alu_csr_unit_if.slave   bus
);

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_SLL  = 4'd2;
  localparam logic [3:0] C_SLT  = 4'd3;
  localparam logic [3:0] C_SLTU = 4'd4;
  localparam logic [3:0] C_XOR  = 4'd5;
  localparam logic [3:0] C_SRL  = 4'd6;
  localparam logic [3:0] C_SRA  = 4'd7;
  localparam logic [3:0] C_OR   = 4'd8;
  localparam logic [3:0] C_AND  = 4'd9;
  localparam logic [3:0] C_BEQ  = 4'd10;
  localparam logic [3:0] C_BNE  = 4'd11;
  localparam logic [3:0] C_BLT  = 4'd12;
  localparam logic [3:0] C_BGE  = 4'd13;
  localparam logic [3:0] C_BLTU = 4'd14;
  localparam logic [3:0] C_BGEU = 4'd15;

  logic [3:0]      alu_ctrl_s;
  logic [XLEN-1:0] alu_s;
  logic            br_s;
  logic [4:0]      shamt_s;
  logic            wr_ok_s;
  logic            priv_ok_s;
  logic [XLEN-1:0] csr_rd_s;
  logic we_mstatus_s, we_mtvec_s, we_mepc_s, we_mcause_s, we_mtval_s, we_satp_s, we_sepc_s;
  logic [XLEN-1:0] mstatus_d, mtvec_d, mepc_d, mcause_d, mtval_d, satp_d, sepc_d;
  logic [XLEN-1:0] mstatus_q, mtvec_q, mepc_q, mcause_q, mtval_q, satp_q, sepc_q;

  // ALU-control decode from op class and funct fields
  always_comb begin
    alu_ctrl_s = C_ADD;
    case (bus.alu_op)
      3'b001: begin
        case (bus.func3)
          3'b001:  alu_ctrl_s = C_BNE;
          3'b100:  alu_ctrl_s = C_BLT;
          3'b101:  alu_ctrl_s = C_BGE;
          3'b110:  alu_ctrl_s = C_BLTU;
          3'b111:  alu_ctrl_s = C_BGEU;
          default: alu_ctrl_s = C_BEQ;
        endcase
      end
      3'b010, 3'b011: begin
        case (bus.func3)
          3'b000:  alu_ctrl_s = (bus.func7 && (bus.alu_op == 3'b010)) ? C_SUB : C_ADD;
          3'b001:  alu_ctrl_s = C_SLL;
          3'b010:  alu_ctrl_s = C_SLT;
          3'b011:  alu_ctrl_s = C_SLTU;
          3'b100:  alu_ctrl_s = C_XOR;
          3'b101:  alu_ctrl_s = bus.func7 ? C_SRA : C_SRL;
          3'b110:  alu_ctrl_s = C_OR;
          default: alu_ctrl_s = C_AND;
        endcase
      end
      default: alu_ctrl_s = C_ADD;
    endcase
  end

  assign shamt_s = bus.op_b[4:0];

  // Combinational ALU; branch codes report the compare outcome in bit 0
  always_comb begin
    br_s  = 1'b0;
    alu_s = {XLEN{1'b0}};
    case (alu_ctrl_s)
      C_ADD:   alu_s = bus.op_a + bus.op_b;
      C_SUB:   alu_s = bus.op_a - bus.op_b;
      C_SLL:   alu_s = bus.op_a << shamt_s;
      C_SLT:   alu_s = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      C_SLTU:  alu_s = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      C_XOR:   alu_s = bus.op_a ^ bus.op_b;
      C_SRL:   alu_s = bus.op_a >> shamt_s;
      C_SRA:   alu_s = $unsigned($signed(bus.op_a) >>> shamt_s);
      C_OR:    alu_s = bus.op_a | bus.op_b;
      C_AND:   alu_s = bus.op_a & bus.op_b;
      C_BEQ:   br_s  = (bus.op_a == bus.op_b);
      C_BNE:   br_s  = (bus.op_a != bus.op_b);
      C_BLT:   br_s  = ($signed(bus.op_a) < $signed(bus.op_b));
      C_BGE:   br_s  = ($signed(bus.op_a) >= $signed(bus.op_b));
      C_BLTU:  br_s  = (bus.op_a < bus.op_b);
      default: br_s  = (bus.op_a >= bus.op_b);
    endcase
    if (alu_ctrl_s >= C_BEQ) begin
      alu_s = {{(XLEN-1){1'b0}}, br_s};
    end else begin
      alu_s = alu_s;
    end
  end

`ifdef CSR_PRIV_CHECK_EN
  // 0x3xx needs M-mode, 0x1xx needs S or M; only those ranges are implemented
  always_comb begin
    case (bus.csr_w_addr[11:8])
      4'h3:    priv_ok_s = (bus.priv_mode == 2'b11);
      4'h1:    priv_ok_s = (bus.priv_mode == 2'b11) || (bus.priv_mode == 2'b01);
      default: priv_ok_s = 1'b0;
    endcase
  end
`else
  logic unused_priv_s;
  assign unused_priv_s = ^bus.priv_mode;
  assign priv_ok_s     = 1'b1;
`endif

  assign wr_ok_s = bus.csr_w_en & priv_ok_s;

  // Per-register write enables; unimplemented addresses enable nothing
  always_comb begin
    we_mstatus_s = 1'b0;
    we_mtvec_s   = 1'b0;
    we_mepc_s    = 1'b0;
    we_mcause_s  = 1'b0;
    we_mtval_s   = 1'b0;
    we_satp_s    = 1'b0;
    we_sepc_s    = 1'b0;
    case (bus.csr_w_addr)
      12'h300: we_mstatus_s = wr_ok_s;
      12'h305: we_mtvec_s   = wr_ok_s;
      12'h341: we_mepc_s    = wr_ok_s;
      12'h342: we_mcause_s  = wr_ok_s;
      12'h343: we_mtval_s   = wr_ok_s;
      12'h180: we_satp_s    = wr_ok_s;
      12'h141: we_sepc_s    = wr_ok_s;
      default: we_mstatus_s = 1'b0;
    endcase
  end

  // Next-state values; exception PCs are kept word aligned
  always_comb begin
    mstatus_d = we_mstatus_s ? bus.csr_w_data : mstatus_q;
    mtvec_d   = we_mtvec_s   ? bus.csr_w_data : mtvec_q;
    mepc_d    = we_mepc_s    ? {bus.csr_w_data[XLEN-1:2], 2'b00} : mepc_q;
    mcause_d  = we_mcause_s  ? bus.csr_w_data : mcause_q;
    mtval_d   = we_mtval_s   ? bus.csr_w_data : mtval_q;
    satp_d    = we_satp_s    ? bus.csr_w_data : satp_q;
    sepc_d    = we_sepc_s    ? {bus.csr_w_data[XLEN-1:2], 2'b00} : sepc_q;
  end

  // CSR state; reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= {XLEN{1'b0}};
      mtvec_q   <= {XLEN{1'b0}};
      mepc_q    <= {XLEN{1'b0}};
      mcause_q  <= {XLEN{1'b0}};
      mtval_q   <= {XLEN{1'b0}};
      satp_q    <= {XLEN{1'b0}};
      sepc_q    <= {XLEN{1'b0}};
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mtval_q   <= mtval_d;
      satp_q    <= satp_d;
      sepc_q    <= sepc_d;
    end
  end

  // Combinational read from registered state, so a same-cycle write is not seen
  always_comb begin
    case (bus.csr_r_addr)
      12'h300: csr_rd_s = mstatus_q;
      12'h305: csr_rd_s = mtvec_q;
      12'h341: csr_rd_s = mepc_q;
      12'h342: csr_rd_s = mcause_q;
      12'h343: csr_rd_s = mtval_q;
      12'h180: csr_rd_s = satp_q;
      12'h141: csr_rd_s = sepc_q;
      default: csr_rd_s = {XLEN{1'b0}};
    endcase
  end

  assign bus.alu_ctrl   = alu_ctrl_s;
  assign bus.alu_o      = alu_s;
  assign bus.br_mark    = br_s;
  assign bus.csr_r_data = csr_rd_s;
  assign bus.result     = bus.csr_sel ? csr_rd_s : alu_s;
  assign bus.o_mstatus  = mstatus_q;
  assign bus.o_mtvec    = mtvec_q;
  assign bus.o_mepc     = mepc_q;
  assign bus.o_mcause   = mcause_q;
  assign bus.o_mtval    = mtval_q;
  assign bus.o_satp     = satp_q;
  assign bus.o_sepc     = sepc_q;

endmodule

// File: tb/tb_ex_alu_csr_unit.sv
// Scoreboard bench for ex_alu_csr_unit: expectations are queued as stimulus is
// driven and drained against the DUT outputs once they have settled.
module tb_ex_alu_csr_unit;

  logic clk;
  logic rst;

  ex_alu_csr_unit_if #(.XLEN(32)) bus ();

  ex_alu_csr_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_CTRL = 0, S_ALU = 1, S_BR = 2, S_RES = 3, S_RD = 4;
  localparam int S_MSTATUS = 5, S_MTVEC = 6, S_MEPC = 7, S_MCAUSE = 8;
  localparam int S_MTVAL = 9, S_SATP = 10, S_SEPC = 11;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks_cnt;
  int   errors_cnt;

  logic [31:0] e_mstatus, e_mtvec, e_mepc, e_mcause, e_mtval, e_satp, e_sepc;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_CTRL:    return {28'd0, bus.alu_ctrl};
      S_ALU:     return bus.alu_o;
      S_BR:      return {31'd0, bus.br_mark};
      S_RES:     return bus.result;
      S_RD:      return bus.csr_r_data;
      S_MSTATUS: return bus.o_mstatus;
      S_MTVEC:   return bus.o_mtvec;
      S_MEPC:    return bus.o_mepc;
      S_MCAUSE:  return bus.o_mcause;
      S_MTVAL:   return bus.o_mtval;
      S_SATP:    return bus.o_satp;
      default:   return bus.o_sepc;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic run_alu(input string tag, input logic [2:0] op, input logic [2:0] f3,
                         input logic f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl, input logic [31:0] res, input logic br);
    @(negedge clk);
    bus.alu_op  = op;
    bus.func3   = f3;
    bus.func7   = f7;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.csr_sel = 1'b0;
    push({tag, "_ctrl"}, S_CTRL, {28'd0, ctrl});
    push({tag, "_alu"},  S_ALU,  res);
    push({tag, "_br"},   S_BR,   {31'd0, br});
    push({tag, "_res"},  S_RES,  res);
    drain();
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data, input logic [1:0] priv);
    @(negedge clk);
    bus.csr_w_en   = 1'b1;
    bus.csr_w_addr = addr;
    bus.csr_w_data = data;
    bus.priv_mode  = priv;
    @(negedge clk);
    bus.csr_w_en   = 1'b0;
  endtask

  task automatic push_all_csr(input string tag);
    push({tag, "_mstatus"}, S_MSTATUS, e_mstatus);
    push({tag, "_mtvec"},   S_MTVEC,   e_mtvec);
    push({tag, "_mepc"},    S_MEPC,    e_mepc);
    push({tag, "_mcause"},  S_MCAUSE,  e_mcause);
    push({tag, "_mtval"},   S_MTVAL,   e_mtval);
    push({tag, "_satp"},    S_SATP,    e_satp);
    push({tag, "_sepc"},    S_SEPC,    e_sepc);
  endtask

  task automatic check_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_r_addr = addr;
    bus.csr_sel    = 1'b1;
    push({tag, "_rd"},  S_RD,  exp);
    push({tag, "_res"}, S_RES, exp);
    drain();
  endtask

  initial begin
    checks_cnt     = 0;
    errors_cnt     = 0;
    rst            = 1'b0;
    bus.alu_op     = 3'b000;
    bus.func3      = 3'b000;
    bus.func7      = 1'b0;
    bus.op_a       = 32'd0;
    bus.op_b       = 32'd0;
    bus.csr_sel    = 1'b0;
    bus.csr_w_en   = 1'b0;
    bus.csr_w_addr = 12'h000;
    bus.csr_w_data = 32'd0;
    bus.csr_r_addr = 12'h000;
    bus.priv_mode  = 2'b11;

    // Reset with a simultaneous write: reset must win
    @(negedge clk);
    rst            = 1'b1;
    bus.csr_w_en   = 1'b1;
    bus.csr_w_addr = 12'h300;
    bus.csr_w_data = 32'hFFFF_FFFF;
    @(negedge clk);
    rst            = 1'b0;
    bus.csr_w_en   = 1'b0;
    {e_mstatus, e_mtvec, e_mepc, e_mcause, e_mtval, e_satp, e_sepc} = '0;
    push_all_csr("rst");
    drain();
    check_read("rst_mstatus", 12'h300, 32'd0);

    run_alu("sub",     3'b010, 3'b000, 1'b1, 32'd5,         32'd7,         4'd1,  32'hFFFF_FFFE, 1'b0);
    run_alu("srai",    3'b011, 3'b101, 1'b1, 32'h8000_0000, 32'd4,         4'd7,  32'hF800_0000, 1'b0);
    run_alu("srli",    3'b011, 3'b101, 1'b0, 32'h8000_0000, 32'd4,         4'd6,  32'h0800_0000, 1'b0);
    run_alu("srl_b5",  3'b010, 3'b101, 1'b0, 32'h8000_0000, 32'h21,        4'd6,  32'h4000_0000, 1'b0);
    run_alu("add_wr",  3'b010, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd2,         4'd0,  32'd1,         1'b0);
    run_alu("addi_f7", 3'b011, 3'b000, 1'b1, 32'd10,        32'd3,         4'd0,  32'd13,        1'b0);
    run_alu("sll",     3'b010, 3'b001, 1'b0, 32'd1,         32'h24,        4'd2,  32'h10,        1'b0);
    run_alu("slt",     3'b010, 3'b010, 1'b0, 32'hFFFF_FFFE, 32'd1,         4'd3,  32'd1,         1'b0);
    run_alu("sltu",    3'b010, 3'b011, 1'b0, 32'hFFFF_FFFE, 32'd1,         4'd4,  32'd0,         1'b0);
    run_alu("xor",     3'b010, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5,  32'h0FF0_0FF0, 1'b0);
    run_alu("or",      3'b010, 3'b110, 1'b0, 32'hF0F0_F0F0, 32'h0F00_0000, 4'd8,  32'hFFF0_F0F0, 1'b0);
    run_alu("and",     3'b010, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9,  32'h00F0_00F0, 1'b0);
    run_alu("lui",     3'b100, 3'b011, 1'b1, 32'd0,         32'hABCD_E000, 4'd0,  32'hABCD_E000, 1'b0);
    run_alu("op111",   3'b111, 3'b111, 1'b1, 32'd2,         32'd3,         4'd0,  32'd5,         1'b0);
    run_alu("blt",     3'b001, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1,         4'd12, 32'd1,         1'b1);
    run_alu("bltu",    3'b001, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1,         4'd14, 32'd0,         1'b0);
    run_alu("beq",     3'b001, 3'b000, 1'b0, 32'd3,         32'd3,         4'd10, 32'd1,         1'b1);
    run_alu("bne",     3'b001, 3'b001, 1'b0, 32'd3,         32'd4,         4'd11, 32'd1,         1'b1);
    run_alu("bge",     3'b001, 3'b101, 1'b0, 32'h8000_0000, 32'd0,         4'd13, 32'd0,         1'b0);
    run_alu("bgeu",    3'b001, 3'b111, 1'b0, 32'h8000_0000, 32'd0,         4'd15, 32'd1,         1'b1);
    run_alu("beq_f3",  3'b001, 3'b011, 1'b0, 32'd5,         32'd6,         4'd10, 32'd0,         1'b0);

    // M-mode writes to every CSR; exception PCs drop the low two bits
    bus.alu_op = 3'b000;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;
    csr_write(12'h341, 32'h8000_0007, 2'b11);
    e_mepc = 32'h8000_0004;
    push_all_csr("mepc");
    drain();
    check_read("mepc", 12'h341, 32'h8000_0004);

    csr_write(12'h300, 32'h0000_1888, 2'b11); e_mstatus = 32'h0000_1888;
    csr_write(12'h305, 32'h8000_0100, 2'b11); e_mtvec   = 32'h8000_0100;
    csr_write(12'h342, 32'h8000_000B, 2'b11); e_mcause  = 32'h8000_000B;
    csr_write(12'h343, 32'hDEAD_BEEF, 2'b11); e_mtval   = 32'hDEAD_BEEF;
    csr_write(12'h180, 32'h8001_2345, 2'b11); e_satp    = 32'h8001_2345;
    csr_write(12'h141, 32'h0000_1003, 2'b11); e_sepc    = 32'h0000_1000;
    push_all_csr("mwr");
    drain();
    check_read("rd_mstatus", 12'h300, 32'h0000_1888);
    check_read("rd_mtvec",   12'h305, 32'h8000_0100);
    check_read("rd_mtval",   12'h343, 32'hDEAD_BEEF);
    check_read("rd_satp",    12'h180, 32'h8001_2345);
    check_read("rd_sepc",    12'h141, 32'h0000_1000);

    // Lower-privilege writes
    csr_write(12'h305, 32'h0000_0100, 2'b01);
`ifndef CSR_PRIV_CHECK_EN
    e_mtvec = 32'h0000_0100;
`endif
    csr_write(12'h180, 32'h0000_0055, 2'b01); e_satp = 32'h0000_0055;
    csr_write(12'h141, 32'h0000_0008, 2'b00);
`ifndef CSR_PRIV_CHECK_EN
    e_sepc = 32'h0000_0008;
`endif
    push_all_csr("priv");
    drain();

    // Unimplemented address: nothing changes, reads zero
    csr_write(12'h7C0, 32'h0000_1234, 2'b11);
    push_all_csr("unimp");
    drain();
    check_read("unimp", 12'h7C0, 32'd0);

    // Same-cycle read/write returns the old value, new value one cycle later
    @(negedge clk);
    bus.csr_w_en   = 1'b1;
    bus.csr_w_addr = 12'h342;
    bus.csr_w_data = 32'h0000_0011;
    bus.priv_mode  = 2'b11;
    check_read("rw_old", 12'h342, 32'h8000_000B);
    @(negedge clk);
    bus.csr_w_en = 1'b0;
    check_read("rw_new", 12'h342, 32'h0000_0011);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
